bitwise_logic_pipe: RTL and testbench

BITWISE_LOGIC_PIPE -- requirements
Module: bitwise_logic_pipe

---
 rtl/aes_logic_pkg.sv | 15 +
 rtl/logic_pipe_stage.sv | 59 +++++
 rtl/bitwise_logic_pipe.sv | 96 +++++++++
 tb/tb_bitwise_logic_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_logic_pkg.sv
// Shared types and limits for the bitwise logic pipeline.
// Holds the operation encoding and the parameter bounds.
package aes_logic_pkg;

    localparam int MAX_WIDTH  = 256;
    localparam int MAX_STAGES = 8;

    typedef enum logic [1:0] {
        MODE_AND  = 2'b00,
        MODE_OR   = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_ANDN = 2'b11
    } logic_mode_e;

endpackage

// File: rtl/logic_pipe_stage.sv
// One pipeline slot: valid bit, result word and zero flag.
// Ready looks through to downstream so bubbles collapse.
module logic_pipe_stage #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid_i,
    output logic             up_ready_o,
    input  logic [WIDTH-1:0] up_data_i,
    input  logic             up_zero_i,
    output logic             valid_o,
    input  logic             down_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o
);

    logic             valid_q, valid_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             advance;
    logic             load;

    assign advance    = valid_q & down_ready_i;
    assign up_ready_o = !valid_q | advance;
    assign load       = up_valid_i & up_ready_o;

    // Load from upstream wins; otherwise empty the slot when it advances.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        zero_d  = zero_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = up_data_i;
            zero_d  = up_zero_i;
        end else if (advance) begin
            valid_d = 1'b0;
        end
    end

    // Slot state; reset empties the slot and clears its payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign zero_o  = zero_q;

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Elastic pipeline computing AND/OR/XOR/ANDN of two operands.
// The result and its zero flag are formed before stage 0.
module bitwise_logic_pipe
    import aes_logic_pkg::*;
#(
    parameter int WIDTH  = 128,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             busy
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $fatal(1, "bitwise_logic_pipe: WIDTH out of range");
    end
    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $fatal(1, "bitwise_logic_pipe: STAGES out of range");
    end

    logic_mode_e                  mode;
    logic [WIDTH-1:0]             res_d;
    logic                         zero_d;
    logic [STAGES-1:0]            valid;
    logic [STAGES-1:0]            ready;
    logic [STAGES-1:0]            up_valid;
    logic [STAGES-1:0]            down_ready;
    logic [STAGES-1:0]            zero;
    logic [STAGES-1:0]            up_zero;
    logic [STAGES-1:0][WIDTH-1:0] data;
    logic [STAGES-1:0][WIDTH-1:0] up_data;

    assign mode = logic_mode_e'(in_mode);

    // Operation select on the incoming operand set.
    always_comb begin
        res_d = '0;
        unique case (mode)
            MODE_AND:  res_d = in_a & in_b;
            MODE_OR:   res_d = in_a | in_b;
            MODE_XOR:  res_d = in_a ^ in_b;
            MODE_ANDN: res_d = in_a & ~in_b;
        endcase
    end

    assign zero_d = ~|res_d;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign up_valid[k] = in_valid;
            assign up_data[k]  = res_d;
            assign up_zero[k]  = zero_d;
        end else begin : g_body
            assign up_valid[k] = valid[k-1];
            assign up_data[k]  = data[k-1];
            assign up_zero[k]  = zero[k-1];
        end

        if (k == STAGES - 1) begin : g_tail
            assign down_ready[k] = out_ready;
        end else begin : g_link
            assign down_ready[k] = ready[k+1];
        end

        logic_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .up_valid_i  (up_valid[k]),
            .up_ready_o  (ready[k]),
            .up_data_i   (up_data[k]),
            .up_zero_i   (up_zero[k]),
            .valid_o     (valid[k]),
            .down_ready_i(down_ready[k]),
            .data_o      (data[k]),
            .zero_o      (zero[k])
        );
    end

    assign in_ready  = ready[0];
    assign out_valid = valid[STAGES-1];
    assign out_y     = data[STAGES-1];
    assign out_zero  = zero[STAGES-1];
    assign busy      = |valid;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe: 8-bit/2-stage and
// 128-bit/1-stage instances against a plain-arithmetic model.
module tb_bitwise_logic_pipe;

    typedef struct {
        logic [127:0] y;
        logic         z;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic         rst8 = 1'b1, iv8 = 1'b0, ir8, ov8, or8 = 1'b1;
    logic         z8, busy8;
    logic [7:0]   a8 = '0, b8 = '0, y8;
    logic [1:0]   m8 = '0;
    logic         rst1 = 1'b1, iv1 = 1'b0, ir1, ov1, or1 = 1'b1;
    logic         z1, busy1;
    logic [127:0] a1 = '0, b1 = '0, y1;
    logic [1:0]   m1 = '0;

    exp_t q8[$];
    exp_t q1[$];
    bit   exact8 = 1'b0, exact1 = 1'b1;
    bit   held8 = 1'b0, held1 = 1'b0;
    logic [7:0]   hy8;
    logic [127:0] hy1;
    logic         hz8, hz1;

    bitwise_logic_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8),
        .in_a(a8), .in_b(b8), .in_mode(m8), .out_valid(ov8),
        .out_ready(or8), .out_y(y8), .out_zero(z8), .busy(busy8)
    );

    bitwise_logic_pipe #(.WIDTH(128), .STAGES(1)) u_dut128 (
        .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1),
        .in_a(a1), .in_b(b1), .in_mode(m1), .out_valid(ov1),
        .out_ready(or1), .out_y(y1), .out_zero(z1), .busy(busy1)
    );

    function automatic logic [127:0] model(input int mode,
                                           input logic [127:0] a,
                                           input logic [127:0] b,
                                           input int w);
        logic [127:0] r, mask;
        case (mode)
            0:       r = a & b;
            1:       r = a | b;
            2:       r = a ^ b;
            default: r = a & ~b;
        endcase
        mask = (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
        return r & mask;
    endfunction

    task automatic chk(input bit ok, input string name,
                       input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard for the 8-bit instance.
    always @(negedge clk) begin
        exp_t e;
        logic [127:0] ey;
        if (rst8) begin
            held8 = 1'b0;
        end else begin
            if (held8)
                chk(ov8 && y8 === hy8 && z8 === hz8, "hold8",
                    128'({ov8, z8, y8}), 128'({1'b1, hz8, hy8}));
            if (ov8 && !held8 && q8.size() > 0)
                chk(exact8 ? (cyc - q8[0].acc == 2) : (cyc - q8[0].acc >= 2),
                    "lat8", 128'(cyc - q8[0].acc), 128'd2);
            if (ov8 && or8) begin
                if (q8.size() == 0) begin
                    chk(1'b0, "extra8", 128'(y8), 128'd0);
                end else begin
                    e = q8.pop_front();
                    chk(y8 === e.y[7:0] && z8 === e.z, "data8",
                        128'({z8, y8}), 128'({e.z, e.y[7:0]}));
                end
            end
            if (iv8 && ir8) begin
                ey = model(int'(m8), 128'(a8), 128'(b8), 8);
                q8.push_back('{y: ey, z: (ey == '0), acc: cyc});
            end
            held8 = ov8 && !or8;
            hy8 = y8;
            hz8 = z8;
        end
    end

    // Monitor / scoreboard for the 128-bit instance.
    always @(negedge clk) begin
        exp_t e;
        logic [127:0] ey;
        if (rst1) begin
            held1 = 1'b0;
        end else begin
            if (held1)
                chk(ov1 && y1 === hy1 && z1 === hz1, "hold128", y1, hy1);
            if (ov1 && !held1 && q1.size() > 0)
                chk(exact1 ? (cyc - q1[0].acc == 1) : (cyc - q1[0].acc >= 1),
                    "lat128", 128'(cyc - q1[0].acc), 128'd1);
            if (ov1 && or1) begin
                if (q1.size() == 0) begin
                    chk(1'b0, "extra128", y1, 128'd0);
                end else begin
                    e = q1.pop_front();
                    chk(y1 === e.y && z1 === e.z, "data128", y1, e.y);
                end
            end
            if (iv1 && ir1) begin
                ey = model(int'(m1), a1, b1, 128);
                q1.push_back('{y: ey, z: (ey == '0), acc: cyc});
            end
            held1 = ov1 && !or1;
            hy1 = y1;
            hz1 = z1;
        end
    end

    task automatic rand8();
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        m8 = 2'($urandom);
    endtask

    task automatic drain8();
        int n = 0;
        iv8 = 1'b0;
        or8 = 1'b1;
        while ((q8.size() != 0 || busy8) && n < 50) begin
            tick();
            n++;
        end
        @(negedge clk);
        chk(q8.size() == 0 && !busy8, "drain8", 128'(q8.size()), 128'd0);
    endtask

    task automatic drain1();
        int n = 0;
        iv1 = 1'b0;
        or1 = 1'b1;
        while ((q1.size() != 0 || busy1) && n < 50) begin
            tick();
            n++;
        end
        @(negedge clk);
        chk(q1.size() == 0 && !busy1, "drain128", 128'(q1.size()), 128'd0);
    endtask

    initial begin
        int acc;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(!ov8 && y8 == 8'h00 && !z8 && !busy8, "rst_state8",
            128'({ov8, z8, busy8, y8}), 128'd0);
        chk(ir8 === 1'b1, "rst_ready8", 128'(ir8), 128'd1);
        chk(!ov1 && y1 == '0 && !z1 && !busy1, "rst_state128", y1, 128'd0);
        chk(ir1 === 1'b1, "rst_ready128", 128'(ir1), 128'd1);
        tick();
        rst8 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        chk(ir8 === 1'b1 && !ov8, "post_rst8", 128'({ir8, ov8}), 128'd2);

        // All four modes back to back, then the zero-flag pair.
        exact8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            iv8 = 1'b1;
            a8 = 8'hF0;
            b8 = 8'h3C;
            m8 = 2'(i);
        end
        tick();
        a8 = 8'hAA; b8 = 8'hAA; m8 = 2'b10;
        tick();
        a8 = 8'hAA; b8 = 8'h55; m8 = 2'b01;
        tick();
        drain8();
        exact8 = 1'b0;

        // Backpressure with continuous offers.
        acc = 0;
        or8 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            iv8 = 1'b1;
            rand8();
            @(negedge clk);
            if (ir8) acc++;
        end
        chk(acc == 2, "bp_accepts", 128'(acc), 128'd2);
        chk(ir8 === 1'b0, "bp_ready", 128'(ir8), 128'd0);
        tick();
        drain8();

        // Bubble collapse behind a stalled last stage.
        tick();
        or8 = 1'b0;
        iv8 = 1'b1;
        rand8();
        tick();
        iv8 = 1'b0;
        tick();
        iv8 = 1'b1;
        rand8();
        @(negedge clk);
        chk(ir8 === 1'b1, "bubble_accept", 128'(ir8), 128'd1);
        tick();
        rand8();
        @(negedge clk);
        chk(ir8 === 1'b0, "bubble_full", 128'(ir8), 128'd0);
        tick();
        drain8();

        // Random traffic on both ends.
        for (int i = 0; i < 300; i++) begin
            tick();
            iv8 = ($urandom_range(0, 3) != 0);
            or8 = ($urandom_range(0, 2) != 0);
            rand8();
        end
        tick();
        drain8();

        // Reset with two items in flight.
        tick();
        or8 = 1'b0;
        iv8 = 1'b1;
        rand8();
        tick();
        rand8();
        tick();
        iv8 = 1'b0;
        rst8 = 1'b1;
        @(negedge clk);
        chk(!ov8 && !busy8 && ir8 === 1'b1, "midrst",
            128'({ov8, busy8, ir8}), 128'd1);
        q8.delete();
        tick();
        rst8 = 1'b0;
        or8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk(!ov8, "midrst_silent", 128'(ov8), 128'd0);
            tick();
        end

        // Wide single-stage instance under random backpressure.
        for (int i = 0; i < 400; i++) begin
            tick();
            iv1 = ($urandom_range(0, 3) != 0);
            or1 = ($urandom_range(0, 2) != 0);
            a1 = {$urandom, $urandom, $urandom, $urandom};
            b1 = ($urandom_range(0, 7) == 0) ? a1
                 : {$urandom, $urandom, $urandom, $urandom};
            m1 = 2'($urandom);
        end
        tick();
        drain1();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
